// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and lane helpers for the MEM-stage data-bus sequencer.
// All lane helpers assume a 32-bit data path with 4 little-endian byte lanes.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    UWORD = 2'b10,
    WORD  = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } mac_state_t;

  function automatic logic [3:0] gen_strb(input mem_size_t size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      BYTE:    s = 4'b0001 << off;
      HALF:    s = 4'b0011 << {off[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rep_wdata(input mem_size_t size, input logic [31:0] w);
    logic [31:0] r;
    case (size)
      BYTE:    r = {4{w[7:0]}};
      HALF:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input mem_size_t size, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (size)
      BYTE:    r = {{24{sgn & b[7]}}, b};
      HALF:    r = {{16{sgn & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_memerror.sv
// Alignment-check gadget: flags misaligned half/word accesses as AdEL/AdES.
// Size UWORD (LWL/LWR/SWL/SWR) is deliberately never checked.
module memerror
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  mem_size_t  size,
  input  logic       wr,
  output logic       adel,
  output logic       ades
);

  logic misalign_s;

  // Misalignment decode by access size
  always_comb begin
    misalign_s = 1'b0;
    case (size)
      WORD:    misalign_s = (addr_lo != 2'b00);
      HALF:    misalign_s = addr_lo[0];
      default: misalign_s = 1'b0;
    endcase
  end

  assign adel = misalign_s & ~wr;
  assign ades = misalign_s & wr;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer onto a single-outstanding sram-like bus.
// One transaction in flight; flushed transactions finish the bus handshake silently.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_adel,
  output logic              resp_ades,
  output logic [ADDR_W-1:0] resp_badvaddr
);

  mac_state_t        state_r, state_s;
  logic              killed_r, killed_s;
  logic              wr_r, signed_r, err_r;
  mem_size_t         size_r, req_size_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic [3:0]        strb_r;
  logic              accept_s, adel_s, ades_s, cap_s, in_addr_s;

  assign req_size_s = mem_size_t'(req_size);
  assign accept_s   = (state_r == IDLE) && req_valid && !flush;
  assign cap_s      = ((state_r == ADDR) && bus_addr_ok && bus_data_ok) ||
                      ((state_r == DATA) && bus_data_ok);

  memerror u_memerror (
    .addr_lo (req_addr[1:0]),
    .size    (req_size_s),
    .wr      (req_wr),
    .adel    (adel_s),
    .ades    (ades_s)
  );

  // Next-state and kill tracking
  always_comb begin
    state_s  = state_r;
    killed_s = killed_r;
    case (state_r)
      IDLE: begin
        killed_s = 1'b0;
        if (accept_s) begin
          state_s = (adel_s || ades_s) ? RESP : ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        killed_s = killed_r | flush;
        if (bus_addr_ok) begin
          state_s = bus_data_ok ? RESP : DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        killed_s = killed_r | flush;
        if (bus_data_ok) begin
          state_s = RESP;
        end else begin
          state_s = DATA;
        end
      end
      RESP: begin
        killed_s = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        killed_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State, request latch and load-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      killed_r <= 1'b0;
      wr_r     <= 1'b0;
      signed_r <= 1'b0;
      err_r    <= 1'b0;
      size_r   <= BYTE;
      addr_r   <= '0;
      wdata_r  <= '0;
      strb_r   <= 4'b0000;
      rdata_r  <= '0;
    end else begin
      state_r  <= state_s;
      killed_r <= killed_s;
      if (accept_s) begin
        wr_r     <= req_wr;
        signed_r <= req_signed;
        err_r    <= adel_s | ades_s;
        size_r   <= req_size_s;
        addr_r   <= req_addr;
        wdata_r  <= rep_wdata(req_size_s, req_wdata);
        strb_r   <= req_wr ? gen_strb(req_size_s, req_addr[1:0]) : 4'b0000;
        rdata_r  <= '0;
      end else if (cap_s && !wr_r) begin
        rdata_r <= extend_load(size_r, signed_r, addr_r[1:0], bus_rdata);
      end
    end
  end

  assign in_addr_s = (state_r == ADDR);

  assign req_ready = (state_r == IDLE);
  assign bus_req   = in_addr_s;
  assign bus_wr    = in_addr_s & wr_r;
  assign bus_addr  = in_addr_s ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign bus_wstrb = in_addr_s ? strb_r : 4'b0000;
  assign bus_wdata = (in_addr_s && wr_r) ? wdata_r : '0;

  // A flush arriving in the RESP cycle itself must still suppress the pulse.
  assign resp_valid    = (state_r == RESP) && !killed_r && !flush;
  assign resp_adel     = resp_valid & err_r & ~wr_r;
  assign resp_ades     = resp_valid & err_r & wr_r;
  assign resp_badvaddr = (resp_valid && err_r) ? addr_r : '0;
  assign resp_rdata    = (resp_valid && !err_r && !wr_r) ? rdata_r : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl plus multi-cycle corner sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wr = 1'b0, req_signed = 1'b0, flush = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        bus_req, bus_wr, bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 32'h0;
  logic [3:0]  bus_wstrb;
  logic        resp_valid, resp_adel, resp_ades;
  logic [31:0] resp_rdata, resp_badvaddr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] rrdata;
  } vec_t;

  vec_t vecs[14];

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_adel(resp_adel), .resp_ades(resp_ades), .resp_badvaddr(resp_badvaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    #1;
    check("issue_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    issue(v.wr, v.size, v.sgn, v.addr, v.wdata);
    if (v.err) begin
      check($sformatf("v%0d_noreq", i), {31'b0, bus_req}, 32'd0);
      check($sformatf("v%0d_rvalid", i), {31'b0, resp_valid}, 32'd1);
      check($sformatf("v%0d_adel", i), {31'b0, resp_adel}, {31'b0, ~v.wr});
      check($sformatf("v%0d_ades", i), {31'b0, resp_ades}, {31'b0, v.wr});
      check($sformatf("v%0d_badva", i), resp_badvaddr, v.addr);
    end else begin
      check($sformatf("v%0d_breq", i), {31'b0, bus_req}, 32'd1);
      check($sformatf("v%0d_bwr", i), {31'b0, bus_wr}, {31'b0, v.wr});
      check($sformatf("v%0d_baddr", i), bus_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_strb", i), {28'b0, bus_wstrb}, {28'b0, v.strb});
      if (v.wr) check($sformatf("v%0d_bwdata", i), bus_wdata, v.bwdata);
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = v.rdata;
      #1;
      check($sformatf("v%0d_early", i), {31'b0, resp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
      #1;
      check($sformatf("v%0d_rvalid", i), {31'b0, resp_valid}, 32'd1);
      check($sformatf("v%0d_rdata", i), resp_rdata, v.rrdata);
      check($sformatf("v%0d_noerr", i), {30'b0, resp_adel, resp_ades}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_pulse1", i), {31'b0, resp_valid}, 32'd0);
    check($sformatf("v%0d_idle", i), {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    //          wr    size   sgn   addr          wdata         rdata         err   strb     bwdata        rrdata
    vecs[0]  = '{1'b0, 2'b11, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1'b0, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_5678, 32'h0,        1'b0, 4'b1100, 32'h5678_5678, 32'h0};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 2'b11, 1'b0, 32'h0000_0001, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0003, 32'hA5A5_1234, 32'h0,        1'b0, 4'b1111, 32'hA5A5_1234, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_7FFF, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0,        32'h8001_F00D, 1'b0, 4'b0000, 32'h0,        32'h0000_F00D};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0,        1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'h0,        32'h1234_7F56, 1'b0, 4'b0000, 32'h0,        32'h0000_007F};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0,        32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h0000_4008, 32'h0102_0304, 32'h0,        1'b0, 4'b1111, 32'h0102_0304, 32'h0};

    // reset state
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_breq", {31'b0, bus_req}, 32'd0);
    check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i);

    // addr_ok held off 3 cycles, data_ok two cycles after addr_ok
    issue(1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dly_breq%0d", k), {31'b0, bus_req}, 32'd1);
      check($sformatf("dly_baddr%0d", k), bus_addr, 32'h0000_5000);
      check($sformatf("dly_strb%0d", k), {28'b0, bus_wstrb}, 32'd0);
      check($sformatf("dly_ready%0d", k), {31'b0, req_ready}, 32'd0);
      @(negedge clk); #1;
    end
    check("dly_breq3", {31'b0, bus_req}, 32'd1);
    bus_addr_ok = 1'b1;
    @(negedge clk); bus_addr_ok = 1'b0; #1;
    check("dly_data_breq", {31'b0, bus_req}, 32'd0);
    check("dly_data_ready", {31'b0, req_ready}, 32'd0);
    check("dly_data_rv", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'h1122_3344; #1;
    check("dly_dok_rv", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
    check("dly_rvalid", {31'b0, resp_valid}, 32'd1);
    check("dly_rdata", resp_rdata, 32'h1122_3344);
    @(negedge clk); #1;
    check("dly_pulse1", {31'b0, resp_valid}, 32'd0);
    check("dly_idle", {31'b0, req_ready}, 32'd1);

    // flush during DATA: handshake completes, response suppressed
    issue(1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0);
    bus_addr_ok = 1'b1;
    @(negedge clk); bus_addr_ok = 1'b0; flush = 1'b1; #1;
    check("fl_data_breq", {31'b0, bus_req}, 32'd0);
    @(negedge clk); flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk); bus_data_ok = 1'b0; #1;
    check("fl_no_rvalid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk); #1;
    check("fl_idle", {31'b0, req_ready}, 32'd1);
    check("fl_no_rvalid2", {31'b0, resp_valid}, 32'd0);
    run_vec(1);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b11; req_addr = 32'h0000_7000; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; #1;
    check("flidle_ready", {31'b0, req_ready}, 32'd1);
    check("flidle_breq", {31'b0, bus_req}, 32'd0);

    // flush in RESP suppresses a pending error response
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0001, 32'h0);
    flush = 1'b1; #1;
    check("flresp_rv", {31'b0, resp_valid}, 32'd0);
    check("flresp_ades", {31'b0, resp_ades}, 32'd0);
    @(negedge clk); flush = 1'b0; #1;
    check("flresp_idle", {31'b0, req_ready}, 32'd1);
    check("flresp_rv2", {31'b0, resp_valid}, 32'd0);

    // reset mid-transaction
    issue(1'b1, 2'b11, 1'b0, 32'h0000_8000, 32'hFFFF_0000);
    check("mrst_pre_breq", {31'b0, bus_req}, 32'd1);
    rst_n = 1'b0; #1;
    check("mrst_breq", {31'b0, bus_req}, 32'd0);
    check("mrst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    run_vec(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences MIPS load/store requests from the MEM stage onto the single-outstanding sram-like data bus. Per request: alignment check through the existing alignment-check gadget, byte-strobe generation, write-data lane replication, bus handshake, and load-data extraction with sign/zero extension. Reports AdEL/AdES with BadVAddr instead of issuing the bus access. Sits between the MEM-stage pipeline register and the data-side bus bridge; one transaction in flight at a time.

Parameters:
ADDR_W, 32, request/bus address width
DATA_W, 32, data width; fixed at 32, the strobe and extraction logic is written for 4 byte lanes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage access request
req_ready  out  1  request accepted when req_valid && req_ready
req_wr  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 unchecked word (LWL/LWR/SWL/SWR path), 11 word
req_signed  in  1  sign-extend load result
req_addr  in  32  virtual/physical byte address
req_wdata  in  32  store data, right-justified
flush  in  1  exception/eret flush from a later stage
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
bus_wstrb  out  4  byte strobes; 0000 for loads
bus_wdata  out  32  lane-replicated store data
bus_addr_ok  in  1  address phase accepted
bus_data_ok  in  1  data phase complete
bus_rdata  in  32  read data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_adel  out  1  load address error
resp_ades  out  1  store address error
resp_badvaddr  out  32  faulting address; valid only with adel/ades

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; killed=0; latched request fields 0.
- States: IDLE, ADDR, DATA, RESP. req_ready=1 only in IDLE.
- IDLE: accept when req_valid && !flush. flush in the same cycle blocks acceptance. On accept, latch wr/size/signed/addr/wdata.
  - Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0. Next state RESP with adel=!wr or ades=wr, badvaddr=addr. No bus activity.
  - Aligned: next state ADDR.
- Strobes (little-endian):
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - sizes 10/11: 1111
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as is.
- ADDR: bus_req=1 and bus_* stable until bus_addr_ok.
  - addr_ok && data_ok in the same cycle: next state RESP.
  - addr_ok only: next state DATA.
  - The request is never withdrawn once raised.
- DATA: bus_req=0; wait for bus_data_ok, then next state RESP. bus_rdata is captured on the data_ok cycle.
- RESP: resp_valid=1 for exactly one cycle unless killed; next state IDLE; killed cleared.
- Load extraction:
  - byte lane addr[1:0], half lane addr[1]; sign-extend if signed, else zero-extend.
  - size 10/11 returns bus_rdata unmodified.
- flush:
  - Asserted in ADDR, DATA or RESP: sets killed.
  - Bus handshake still completes, so no protocol violation and no stray data_ok later.
  - resp_valid is suppressed for the killed transaction.
  - An error response pending in RESP is suppressed the same way.
- Minimum latency: aligned access with addr_ok and data_ok in the first ADDR cycle gives resp_valid 2 cycles after acceptance. Error access gives resp_valid 1 cycle after acceptance.
- rst_n low mid-transaction: immediate return to IDLE, bus_req=0. The external bus is reset by the same rst_n.

Decomposition:
- Shared package: mem_size_t (BYTE=2'b00, HALF=2'b01, UWORD=2'b10, WORD=2'b11); FSM state enum; strobe/extension helper functions.
- Sub-module: instantiate the existing alignment-check gadget (memerror) for the error decision.
- Strobe and extraction stay inline.

Test Plan:
- Aligned LW @0x0000_1004, addr_ok+data_ok same cycle, rdata 0xDEADBEEF -> bus_addr 0x1004, wstrb 0000, resp_valid at T+2, rdata 0xDEADBEEF.
- LB signed @0x...1003, rdata 0x80AA_BBCC -> wstrb 0000, resp_rdata 0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH @0x...0002, wdata 0x1234_5678 -> bus_wstrb 1100, bus_wdata 0x5678_5678, bus_addr ...0000.
- LW @0x...0006 -> no bus_req, resp_valid T+1, adel=1, badvaddr 0x...0006. SW @...0001 -> ades=1. Size 10 @...0003 -> no error, wstrb 1111.
- addr_ok held low 3 cycles, then data_ok 2 cycles later -> bus_* stable throughout; single resp_valid; req_ready=0 until back in IDLE.
- flush during DATA -> data_ok consumed, no resp_valid; next request accepted normally. flush with req_valid in IDLE -> not accepted.
